secuenciador_sel: RTL and testbench

SECUENCIADOR_SEL -- requirements
Module: secuenciador_sel

---
 rtl/secuenciador_pkg.sv | 16 +
 rtl/secuenciador_sel_divisor_presc.sv | 38 +++
 rtl/secuenciador_sel.sv | 137 +++++++++++++
 tb/tb_secuenciador_sel.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/secuenciador_pkg.sv
// Shared definitions for the channel sequencer: widths, default hold time
// and the scan state encoding.
package secuenciador_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned PRESC_DEF = 4;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    BARRIDO = 2'd1,
    FIN     = 2'd2
  } estado_t;

endpackage

// File: rtl/secuenciador_sel_divisor_presc.sv
// Hold counter: counts enabled cycles 0..PRESC-1 and flags the terminal count.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear to 0 (priority over en)
//   en         : count enable; wraps to 0 after the terminal count
//   tc_c       : combinational terminal-count flag (count == PRESC-1)
module divisor_presc
  import secuenciador_pkg::*;
#(
  parameter int unsigned PRESC = PRESC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc_c = (cnt_q == CNT_W'(PRESC - 1));

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/secuenciador_sel.sv
// Scans an 8-bit word through an external 8:1 mux: presents the word on i,
// steps the select s through channels 0..7 holding each for PRESC cycles,
// and reassembles the mux output x into captura.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   start       : begin a scan of dato (accepted only in REPOSO)
//   parar       : abort the running scan
//   dato        : word to scan
//   i, s        : registered mux data word and channel select
//   x           : mux output fed back
//   ocupado     : scan in progress (BARRIDO or FIN)
//   bit_valido  : one-cycle pulse per sampled channel
//   fin         : one-cycle pulse during the FIN state
//   captura     : reassembled word, bit k sampled with s=k
module secuenciador_sel
  import secuenciador_pkg::*;
#(
  parameter int unsigned PRESC = PRESC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              parar,
  input  logic [DATA_W-1:0] dato,
  output logic [DATA_W-1:0] i,
  output logic [SEL_W-1:0]  s,
  input  logic              x,
  output logic              ocupado,
  output logic              bit_valido,
  output logic              fin,
  output logic [DATA_W-1:0] captura
);

  estado_t             estado_q, estado_d;
  logic [DATA_W-1:0]   i_q, i_d;
  logic [DATA_W-1:0]   captura_q, captura_d;
  logic [SEL_W-1:0]    s_q, s_d;
  logic                ocupado_q, ocupado_d;
  logic                bit_valido_q, bit_valido_d;
  logic                fin_q, fin_d;
  logic                cnt_clr_c, cnt_en_c, tc_c;
  logic                muestra_c;

  divisor_presc #(.PRESC(PRESC)) u_divisor_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr_c),
    .en    (cnt_en_c),
    .tc_c  (tc_c)
  );

  // A sample is due on the last hold cycle unless an abort wins
  assign muestra_c = (estado_q == BARRIDO) && !parar && tc_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= REPOSO;
    else        estado_q <= estado_d;
  end

  // Next-state logic
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      REPOSO:  if (start) estado_d = BARRIDO;
      BARRIDO: begin
        if (parar)                                   estado_d = REPOSO;
        else if (muestra_c && (s_q == SEL_W'(7)))    estado_d = FIN;
      end
      FIN:     estado_d = REPOSO;
      default: estado_d = REPOSO;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    i_d          = i_q;
    captura_d    = captura_q;
    s_d          = s_q;
    bit_valido_d = 1'b0;
    fin_d        = 1'b0;
    ocupado_d    = (estado_d != REPOSO);
    cnt_clr_c    = 1'b0;
    cnt_en_c     = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (start) begin
          i_d       = dato;
          captura_d = '0;
          s_d       = '0;
          cnt_clr_c = 1'b1;
        end
      end
      BARRIDO: begin
        if (parar) begin
          s_d       = '0;
          cnt_clr_c = 1'b1;
        end else begin
          cnt_en_c = 1'b1;
          if (tc_c) begin
            captura_d[s_q] = x;
            bit_valido_d   = 1'b1;
            s_d            = s_q + SEL_W'(1);  // 7 wraps to 0 on entry to FIN
            fin_d          = (s_q == SEL_W'(7));
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q          <= '0;
      captura_q    <= '0;
      s_q          <= '0;
      ocupado_q    <= 1'b0;
      bit_valido_q <= 1'b0;
      fin_q        <= 1'b0;
    end else begin
      i_q          <= i_d;
      captura_q    <= captura_d;
      s_q          <= s_d;
      ocupado_q    <= ocupado_d;
      bit_valido_q <= bit_valido_d;
      fin_q        <= fin_d;
    end
  end

  assign i          = i_q;
  assign s          = s_q;
  assign captura    = captura_q;
  assign ocupado    = ocupado_q;
  assign bit_valido = bit_valido_q;
  assign fin        = fin_q;

endmodule

// File: tb/tb_secuenciador_sel.sv
// Bench for secuenciador_sel: two instances (PRESC=4 and PRESC=1), each with
// its i/s outputs looped through an 8:1 mux model into x.
module tb_secuenciador_sel;

  logic       clk;
  logic       rst_n;

  logic       start_a, parar_a, x_a, ocup_a, bv_a, fin_a;
  logic [7:0] dato_a, i_a, cap_a;
  logic [2:0] s_a;

  logic       start_b, parar_b, x_b, ocup_b, bv_b, fin_b;
  logic [7:0] dato_b, i_b, cap_b;
  logic [2:0] s_b;

  int checks   = 0;
  int failures = 0;

  logic       exp_bits[$];
  logic [7:0] exp_cap[$];

  secuenciador_sel #(.PRESC(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .parar(parar_a), .dato(dato_a),
    .i(i_a), .s(s_a), .x(x_a), .ocupado(ocup_a), .bit_valido(bv_a),
    .fin(fin_a), .captura(cap_a)
  );

  secuenciador_sel #(.PRESC(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .parar(parar_b), .dato(dato_b),
    .i(i_b), .s(s_b), .x(x_b), .ocupado(ocup_b), .bit_valido(bv_b),
    .fin(fin_b), .captura(cap_b)
  );

  // 8:1 mux in the loop
  assign x_a = i_a[s_a];
  assign x_b = i_b[s_b];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One scan on instance sel (0: PRESC=4, 1: PRESC=1). stop_e>0 asserts parar
  // for that edge; hold keeps start high and swaps dato to d2 mid-scan.
  task automatic scan(input bit sel, input logic [7:0] d, input int stop_e,
                      input bit hold, input logic [7:0] d2);
    int         p, nsamp, nbv;
    bit         stopped, bv_e;
    logic       bit_e;
    logic [7:0] cap_e, i_o, cap_o;
    logic [2:0] s_o, s_e;
    logic       bv_o, fin_o, ocup_o;
    p     = sel ? 1 : 4;
    nsamp = (stop_e > 0) ? (stop_e - 1) / p : 8;
    if (nsamp > 8) nsamp = 8;
    cap_e = 8'h00;
    for (int k = 0; k < nsamp; k++) begin
      cap_e[k] = d[k];
      exp_bits.push_back(d[k]);
    end
    exp_cap.push_back(cap_e);
    nbv = 0;

    if (sel) begin dato_b = d; start_b = 1'b1; end
    else     begin dato_a = d; start_a = 1'b1; end
    @(posedge clk); #1;
    if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
    chk("ocupado_start", sel ? 32'(ocup_b) : 32'(ocup_a), 32'd1);
    chk("s_start",       sel ? 32'(s_b) : 32'(s_a), 32'd0);
    chk("captura_clear", sel ? 32'(cap_b) : 32'(cap_a), 32'd0);

    for (int e = 1; e <= 8 * p + 1; e++) begin
      if (e == stop_e) begin parar_a = !sel; parar_b = sel; end
      if (hold && e == 5) begin if (sel) dato_b = d2; else dato_a = d2; end
      @(posedge clk); #1;
      parar_a = 1'b0; parar_b = 1'b0;
      i_o    = sel ? i_b    : i_a;
      s_o    = sel ? s_b    : s_a;
      cap_o  = sel ? cap_b  : cap_a;
      bv_o   = sel ? bv_b   : bv_a;
      fin_o  = sel ? fin_b  : fin_a;
      ocup_o = sel ? ocup_b : ocup_a;

      stopped = (stop_e > 0) && (e >= stop_e);
      bv_e    = !stopped && (e <= 8 * p) && (e % p == 0);
      s_e     = (stopped || e >= 8 * p) ? 3'd0 : 3'(e / p);
      if (bv_o) nbv++;
      chk("bit_valido", 32'(bv_o), 32'(bv_e));
      if (bv_e && exp_bits.size() > 0) begin
        bit_e = exp_bits.pop_front();
        chk("bit_sample", 32'(cap_o[e / p - 1]), 32'(bit_e));
      end
      chk("fin",     32'(fin_o),  32'(!stopped && e == 8 * p));
      chk("ocupado", 32'(ocup_o), 32'(!stopped && e <= 8 * p));
      chk("s",       32'(s_o),    32'(s_e));
      chk("i_hold",  32'(i_o),    32'(d));
    end
    chk("n_bit_valido", 32'(nbv), 32'(nsamp));
    chk("captura", sel ? 32'(cap_b) : 32'(cap_a), 32'(exp_cap.pop_front()));
  endtask

  initial begin
    int nfin;
    rst_n   = 1'b0;
    start_a = 1'b0; parar_a = 1'b0; dato_a = 8'h00;
    start_b = 1'b0; parar_b = 1'b0; dato_b = 8'h00;
    #12;
    chk("rst_i",       32'(i_a),    32'd0);
    chk("rst_s",       32'(s_a),    32'd0);
    chk("rst_captura", 32'(cap_a),  32'd0);
    chk("rst_ocupado", 32'(ocup_a), 32'd0);
    chk("rst_bv",      32'(bv_a),   32'd0);
    chk("rst_fin",     32'(fin_a),  32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    // start held low after reset release: stays idle
    @(posedge clk); #1;
    chk("idle_ocupado", 32'(ocup_a), 32'd0);

    scan(1'b0, 8'hA5, 0, 1'b0, 8'h00);
    scan(1'b1, 8'h3C, 0, 1'b0, 8'h00);

    // start held, dato changed mid-scan, second scan right after REPOSO
    scan(1'b0, 8'h96, 0, 1'b1, 8'h69);
    scan(1'b0, 8'h69, 0, 1'b0, 8'h00);

    // abort at edge 13
    scan(1'b0, 8'hFF, 13, 1'b0, 8'h00);
    @(posedge clk); #1;
    chk("abort_idle", 32'(ocup_a), 32'd0);

    // reset mid-scan
    dato_a = 8'hC3; start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (9) @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("mrst_i",       32'(i_a),    32'd0);
    chk("mrst_s",       32'(s_a),    32'd0);
    chk("mrst_captura", 32'(cap_a),  32'd0);
    chk("mrst_ocupado", 32'(ocup_a), 32'd0);
    chk("mrst_bv",      32'(bv_a),   32'd0);
    chk("mrst_fin",     32'(fin_a),  32'd0);
    nfin = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (fin_a || bv_a) nfin++;
    end
    chk("mrst_no_pulse", 32'(nfin), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    scan(1'b0, 8'h5A, 0, 1'b0, 8'h00);

    // back-to-back scans
    scan(1'b0, 8'h00, 0, 1'b0, 8'h00);
    scan(1'b0, 8'hFF, 0, 1'b0, 8'h00);
    scan(1'b1, 8'h81, 0, 1'b0, 8'h00);
    scan(1'b1, 8'h7E, 0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
